rx78_clken: RTL
===============

RX78_CLKEN -- requirements
Module: rx78_clken

Interface
REQ-001 Parameter LOCK_WAIT, default 1024: clk_sys cycles of continuous synchronized lock required before the core reset is released.
REQ-002 Parameter PIX_DIV, default 6: pixel enable divisor; at 42 MHz this gives 7 MHz.
REQ-003 Parameter CPU_NUM, default 2: CPU enable fractional increment.
REQ-004 Parameter CPU_DEN, default 23: CPU enable fractional modulus; 42 MHz × 2/23 = 3.652173 MHz.
REQ-005 clk_sys  in  1  system clock, 42 MHz PLL output; the only clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pll_locked  in  1  PLL lock indicator; asynchronous to clk_sys.
REQ-008 pause  in  1  freezes CPU enable generation while high.
REQ-009 core_reset  out  1  active-high reset to the downstream core.
REQ-010 ready  out  1  high only in state RUN.
REQ-011 ce_pix  out  1  one-cycle pixel clock enable.
REQ-012 ce_cpu  out  1  one-cycle CPU clock enable.

Function
REQ-013 pll_locked SHALL pass through a 2-flop synchronizer (lock_s) before any use; lock_s is the only lock signal the FSM sees.
REQ-014 FSM states SHALL be WAIT_LOCK, COUNT and RUN, with the following transitions:
 - WAIT_LOCK -> COUNT when lock_s=1; the lock counter is cleared to 0.
 - COUNT: the counter increments while lock_s=1.
 - COUNT -> RUN on the cycle the counter equals LOCK_WAIT-1.
 - COUNT -> WAIT_LOCK when lock_s=0; the counter is cleared.
 - RUN -> WAIT_LOCK when lock_s=0.
REQ-015 core_reset SHALL be 1 in WAIT_LOCK and COUNT and 0 in RUN; it SHALL be registered, with no combinational path from pll_locked.
REQ-016 ready SHALL equal (state==RUN) and be registered.
REQ-017 ce_pix and ce_cpu SHALL be 0 in every cycle outside RUN.
REQ-018 Pixel divider (0..PIX_DIV-1):
 - SHALL be 0 in the first RUN cycle and wrap to 0 after PIX_DIV-1.
 - ce_pix SHALL be 1 when the divider equals PIX_DIV-1, giving the first pulse in the 6th RUN cycle and then exactly one pulse every 6 cycles.
REQ-019 CPU accumulator acc (width ceil(log2(CPU_DEN+CPU_NUM)), 5 bits at the defaults):
 - SHALL be 0 in the first RUN cycle.
 - Each RUN cycle with pause=0: if acc+CPU_NUM >= CPU_DEN, then acc <= acc+CPU_NUM-CPU_DEN and ce_cpu=1; otherwise acc <= acc+CPU_NUM and ce_cpu=0.
 - With the defaults, pulses SHALL occur in RUN cycles 12, 23, 35, 46, ...; intervals alternate 12, 11, 12, 11; exactly 2 pulses per 23 cycles; no drift.
REQ-020 pause=1 SHALL hold acc and force ce_cpu=0 in that cycle; ce_pix SHALL be unaffected.
REQ-021 When pause deasserts, accumulation SHALL resume from the held acc, with no catch-up burst.
REQ-022 Loss of lock in RUN:
 - In the cycle after lock_s falls, core_reset=1, ready=0 and both enables SHALL be 0.
 - On the next entry to RUN, the dividers and acc SHALL restart from 0.
REQ-023 Lock glitches in COUNT SHALL restart the full LOCK_WAIT qualification; partial counts SHALL NOT accumulate.
REQ-024 ce_pix and ce_cpu MAY coincide in the same cycle; each SHALL be generated independently.

Reset
REQ-025 reset=1 SHALL, on the next clk_sys edge, force the following, overriding all other inputs including lock_s:
 - state=WAIT_LOCK, lock counter=0, pixel divider=0, acc=0;
 - synchronizer flops=0;
 - core_reset=1, ready=0, ce_pix=0, ce_cpu=0.
REQ-026 Reset asserted mid-RUN SHALL take effect in one cycle.
REQ-027 After reset releases, the full sequence SHALL repeat, including synchronizer latency and LOCK_WAIT.

Verification
REQ-028 Startup, LOCK_WAIT=16: pll_locked=1 from cycle 0 after reset releases -> core_reset falls and ready rises after 2 synchronizer cycles plus 16 COUNT cycles, ±1 cycle per the documented edge; no enables before ready.
REQ-029 Enable cadence: run 2300 RUN cycles -> exactly 383 ce_pix and 200 ce_cpu; ce_cpu intervals strictly alternate 12 and 11, first pulse at RUN cycle 12.
REQ-030 Lock glitch: drop pll_locked for 1 cycle when the COUNT counter is at 10 -> FSM returns to WAIT_LOCK and RUN entry is delayed by a full LOCK_WAIT; core_reset stays 1 throughout.
REQ-031 Lock loss in RUN: deassert pll_locked -> within 3 cycles core_reset=1, ready=0 and enables stop; on relock, the first ce_cpu again falls at RUN cycle 12.
REQ-032 Pause: hold pause=1 for 50 cycles mid-RUN -> no ce_cpu, ce_pix continues every 6 cycles; after release the next ce_cpu arrives exactly (CPU_DEN-acc_held)/2 rounded up cycles later.
REQ-033 Reset mid-RUN: assert reset for 1 cycle -> next cycle all outputs are at their reset values; the full qualification then repeats.

Source files
------------

// File: rtl/rx78_clken.sv
// Clock-enable generator: qualifies PLL lock, holds the core in reset until lock is stable,
// then produces pixel and fractional CPU clock enables from the single system clock.
//   state     | meaning
//   WAIT_LOCK | core held in reset, waiting for synchronized lock
//   COUNT     | lock seen, counting LOCK_WAIT continuous locked cycles
//   RUN       | core released, enables running
module rx78_clken #(
    parameter int LOCK_WAIT = 1024,
    parameter int PIX_DIV   = 6,
    parameter int CPU_NUM   = 2,
    parameter int CPU_DEN   = 23
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic pll_locked,
    input  logic pause,
    output logic core_reset,
    output logic ready,
    output logic ce_pix,
    output logic ce_cpu
);
    localparam int CW = $clog2(LOCK_WAIT + 1);
    localparam int PW = $clog2(PIX_DIV + 1);
    localparam int AW = $clog2(CPU_DEN + CPU_NUM);

    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_WAIT - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(PIX_DIV - 1);
    localparam logic [AW:0]   NUM_W    = (AW+1)'(CPU_NUM);
    localparam logic [AW:0]   DEN_W    = (AW+1)'(CPU_DEN);

    typedef enum logic [1:0] {WAIT_LOCK, COUNT, RUN} state_t;

    state_t        state, state_d;
    logic [1:0]    sync;
    logic          lock_s;
    logic [CW-1:0] cnt, cnt_d;
    logic [PW-1:0] pix, pix_d;
    logic [AW-1:0] acc, acc_d;
    logic [AW:0]   acc_sum;
    logic          run, wrap;

    assign lock_s  = sync[1];
    assign run     = (state == RUN);
    assign acc_sum = {1'b0, acc} + NUM_W;
    assign wrap    = (acc_sum >= DEN_W);
    assign ce_pix  = run && (pix == PIX_LAST);
    assign ce_cpu  = run && !pause && wrap;

    always_comb begin
        state_d = state;
        cnt_d   = '0;
        case (state)
            WAIT_LOCK: if (lock_s) state_d = COUNT;
            COUNT: begin
                if (!lock_s)               state_d = WAIT_LOCK;
                else if (cnt == CNT_LAST)  state_d = RUN;
                else                       cnt_d   = cnt + 1'b1;
            end
            RUN:       if (!lock_s) state_d = WAIT_LOCK;
            default:   state_d = WAIT_LOCK;
        endcase
    end

    // Dividers sit at zero outside RUN so every RUN entry starts from a clean phase.
    always_comb begin
        pix_d = '0;
        acc_d = '0;
        if (run) begin
            pix_d = (pix == PIX_LAST) ? '0 : pix + 1'b1;
            if (pause)     acc_d = acc;
            else if (wrap) acc_d = AW'(acc_sum - DEN_W);
            else           acc_d = AW'(acc_sum);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync       <= '0;
            state      <= WAIT_LOCK;
            cnt        <= '0;
            pix        <= '0;
            acc        <= '0;
            core_reset <= 1'b1;
            ready      <= 1'b0;
        end else begin
            sync       <= {sync[0], pll_locked};
            state      <= state_d;
            cnt        <= cnt_d;
            pix        <= pix_d;
            acc        <= acc_d;
            core_reset <= (state_d != RUN);
            ready      <= (state_d == RUN);
        end
    end
endmodule
